// File: rtl/diff_accum_pkg.sv
// Shared types and helpers for the diff_accum window accumulator.
// Holds the FSM encoding and the accumulator width rule.
package diff_pkg;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  // Enough headroom that COUNT samples of WIDTH bits can never overflow.
  function automatic int acc_width(input int w, input int c);
    return w + $clog2(c);
  endfunction

endpackage

// File: rtl/diff_accum_if.sv
// Sample-in / window-sum-out handshake bundle for diff_accum.
// master drives samples and consumes sums; slave is the accumulator.
interface diff_accum_if #(
  parameter int WIDTH = 2,
  parameter int COUNT = 4
);
  import diff_pkg::*;

  localparam int ACC_WIDTH = acc_width(WIDTH, COUNT);

  logic [WIDTH-1:0]     diff_in;
  logic                 diff_valid;
  logic                 diff_ready;
  logic [ACC_WIDTH-1:0] sum_out;
  logic                 sum_valid;
  logic                 sum_ready;

  modport master (
    output diff_in, diff_valid, sum_ready,
    input  diff_ready, sum_out, sum_valid
  );

  modport slave (
    input  diff_in, diff_valid, sum_ready,
    output diff_ready, sum_out, sum_valid
  );

endinterface

// File: rtl/diff_accum.sv
// Sums windows of COUNT accepted diff samples; the sum is held until consumed.
// DIFF_ACCUM_SIGNED_EN selects two's-complement samples (default: unsigned).
module diff_accum
  import diff_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  diff_accum_if.slave  bus
);

  localparam int ACC_WIDTH = acc_width(WIDTH, COUNT);
  localparam int CNT_W     = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  logic [0:0]           state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic                 sum_vld_q;

  logic [ACC_WIDTH-1:0] diff_ext;
  logic                 accept;

`ifdef DIFF_ACCUM_SIGNED_EN
  assign diff_ext = {{(ACC_WIDTH - WIDTH){bus.diff_in[WIDTH-1]}}, bus.diff_in};
`else
  assign diff_ext = {{(ACC_WIDTH - WIDTH){1'b0}}, bus.diff_in};
`endif

  assign bus.diff_ready = (state_q == ACCUM);
  assign accept         = bus.diff_valid && bus.diff_ready;
  assign bus.sum_out    = sum_q;
  assign bus.sum_valid  = sum_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == CNT_LAST) begin
              sum_q     <= acc_q + diff_ext;
              sum_vld_q <= 1'b1;
              acc_q     <= '0;
              cnt_q     <= '0;
              state_q   <= HOLD;
            end else begin
              acc_q <= acc_q + diff_ext;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // Incoming samples stay with the producer until the sum is taken.
          if (sum_vld_q && bus.sum_ready) begin
            sum_vld_q <= 1'b0;
            state_q   <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_accum.sv
// Self-checking bench for diff_accum (WIDTH=2, COUNT=4): directed table,
// a backpressure sequence and randomized traffic against a window model.
module tb_diff_accum;

  localparam int WIDTH     = 2;
  localparam int COUNT     = 4;
  localparam int ACC_WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  diff_accum_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

  diff_accum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit             chk;
    bit             rst_n;
    bit             dv;
    logic [1:0]     d;
    bit             sr;
    bit             e_rdy;
    bit             e_vld;
    logic [3:0]     e_sum;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef DIFF_ACCUM_SIGNED_EN
  localparam logic [3:0] S3 = 4'hF;
`else
  localparam logic [3:0] S3 = 4'h3;
`endif

  // Window model: accepted samples queue up until COUNT of them are summed.
  int         m_q[$];
  bit         m_hold;
  bit         m_vld;
  logic [3:0] m_sum;

  function automatic int sval(input logic [1:0] d);
`ifdef DIFF_ACCUM_SIGNED_EN
    return (int'(d) >= 2) ? int'(d) - 4 : int'(d);
`else
    return int'(d);
`endif
  endfunction

  task automatic model_step(input bit r, input bit dv, input logic [1:0] d, input bit sr);
    int s;
    if (!r) begin
      m_q.delete();
      m_hold = 1'b0;
      m_vld  = 1'b0;
      m_sum  = 4'h0;
    end else if (m_hold) begin
      if (sr) begin
        m_hold = 1'b0;
        m_vld  = 1'b0;
      end
    end else if (dv) begin
      m_q.push_back(sval(d));
      if (m_q.size() == COUNT) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_sum  = s[3:0];
        m_vld  = 1'b1;
        m_hold = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input bit chk, input bit r, input bit dv, input logic [1:0] d,
                     input bit sr, input bit er, input bit ev, input logic [3:0] es);
    vec_t v;
    v.chk = chk; v.rst_n = r; v.dv = dv; v.d = d; v.sr = sr;
    v.e_rdy = er; v.e_vld = ev; v.e_sum = es;
    vt.push_back(v);
  endtask

  task automatic drive(input bit r, input bit dv, input logic [1:0] d, input bit sr);
    rst_n          = r;
    bus.diff_valid = dv;
    bus.diff_in    = d;
    bus.sum_ready  = sr;
  endtask

  task automatic obs(input string tag, input bit er, input bit ev, input logic [3:0] es);
    check({tag, ".rdy"}, 32'(bus.diff_ready), 32'(er));
    check({tag, ".vld"}, 32'(bus.sum_valid), 32'(ev));
    check({tag, ".sum"}, 32'(bus.sum_out), 32'(es));
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 1'b0);

    // chk rst dv d sr | rdy vld sum   (outputs seen before the cycle's edge)
    add(0, 0, 1, 2'd1, 0, 1, 0, 4'h0);   // reset with valid high
    add(1, 0, 1, 2'd1, 0, 1, 0, 4'h0);
    add(1, 1, 0, 2'd0, 0, 1, 0, 4'h0);
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h0);   // 1,1,1,1
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h0);
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h0);
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h0);
    add(1, 1, 0, 2'd0, 1, 0, 1, 4'h4);
    add(1, 1, 0, 2'd0, 1, 1, 0, 4'h4);
    add(1, 1, 1, 2'd2, 1, 1, 0, 4'h4);   // 2,1,0,0
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h4);
    add(1, 1, 1, 2'd0, 1, 1, 0, 4'h4);
    add(1, 1, 1, 2'd0, 1, 1, 0, 4'h4);
    add(1, 1, 0, 2'd0, 1, 0, 1, S3);
    add(1, 1, 0, 2'd0, 1, 1, 0, S3);
    add(1, 1, 1, 2'd3, 1, 1, 0, S3);     // 3,_,_,3,3,_,3
    add(1, 1, 0, 2'd0, 1, 1, 0, S3);
    add(1, 1, 0, 2'd0, 1, 1, 0, S3);
    add(1, 1, 1, 2'd3, 1, 1, 0, S3);
    add(1, 1, 1, 2'd3, 1, 1, 0, S3);
    add(1, 1, 0, 2'd0, 1, 1, 0, S3);
    add(1, 1, 1, 2'd3, 1, 1, 0, S3);
    add(1, 1, 0, 2'd0, 1, 0, 1, 4'hC);
    add(1, 1, 0, 2'd0, 1, 1, 0, 4'hC);
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'hC);   // partial window, then reset
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'hC);
    add(1, 0, 0, 2'd0, 1, 1, 0, 4'hC);
    add(1, 1, 1, 2'd1, 1, 1, 0, 4'h0);   // 1,0,0,0
    add(1, 1, 1, 2'd0, 1, 1, 0, 4'h0);
    add(1, 1, 1, 2'd0, 1, 1, 0, 4'h0);
    add(1, 1, 1, 2'd0, 1, 1, 0, 4'h0);
    add(1, 1, 0, 2'd0, 1, 0, 1, 4'h1);
    add(1, 1, 0, 2'd0, 1, 1, 0, 4'h1);

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].dv, vt[i].d, vt[i].sr);
      @(negedge clk);
      if (vt[i].chk) obs($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_vld, vt[i].e_sum);
      @(posedge clk); #1;
    end

    // Backpressure: window of 1s, then 5 blocked cycles offering value 2.
    for (int i = 0; i < COUNT; i++) begin
      drive(1'b1, 1'b1, 2'd1, 1'b0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0);
      @(negedge clk);
      obs($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 4'h4);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    @(negedge clk);
    obs("bp_release", 1'b0, 1'b1, 4'h4);
    @(posedge clk); #1;
    // A fresh window of 1s must complete after exactly COUNT accepts.
    for (int i = 0; i < COUNT; i++) begin
      drive(1'b1, 1'b1, 2'd1, 1'b0);
      @(negedge clk);
      obs($sformatf("bp_next%0d", i), 1'b1, 1'b0, 4'h4);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    obs("bp_done", 1'b0, 1'b1, 4'h4);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    model_step(1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 600; i++) begin
      bit         r, dv, sr;
      logic [1:0] d;
      r  = ($urandom_range(0, 59) != 0);
      dv = ($urandom_range(0, 3) != 0);
      sr = ($urandom_range(0, 2) != 0);
      d  = 2'($urandom_range(0, 3));
      drive(r, dv, d, sr);
      @(negedge clk);
      obs($sformatf("rnd%0d", i), !m_hold, m_vld, m_sum);
      model_step(r, dv, d, sr);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
